// File: rtl/axi4_write_arbiter_if.sv
// Bundle between the requesters, the write arbiter and the AXI4 master.
// slave: arbiter view; master: view of the requesters plus the AXI4 master.
interface axi4_write_arbiter_if #(
  parameter int N_REQ        = 4,
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 256
);

  logic [N_REQ-1:0]              REQ_VALID;
  logic [N_REQ*P_ADDR_WIDTH-1:0] REQ_ADDR;
  logic [N_REQ*P_DATA_WIDTH-1:0] REQ_DATA;
  logic [N_REQ-1:0]              REQ_ACK;
  logic [N_REQ-1:0]              RSP_VALID;
  logic [N_REQ-1:0]              RSP_ERROR;
  logic                          BUSY;
  logic [2:0]                    GRANT_ID;
  logic                          WRITE_START;
  logic [P_ADDR_WIDTH-1:0]       WRITE_ADDR;
  logic [P_DATA_WIDTH-1:0]       WRITE_DATA;
  logic                          WRITE_READY;
  logic                          WRITE_DONE;
  logic                          WRITE_ERROR;

  modport slave (
    input  REQ_VALID,
    input  REQ_ADDR,
    input  REQ_DATA,
    input  WRITE_READY,
    input  WRITE_DONE,
    input  WRITE_ERROR,
    output REQ_ACK,
    output RSP_VALID,
    output RSP_ERROR,
    output BUSY,
    output GRANT_ID,
    output WRITE_START,
    output WRITE_ADDR,
    output WRITE_DATA
  );

  modport master (
    output REQ_VALID,
    output REQ_ADDR,
    output REQ_DATA,
    output WRITE_READY,
    output WRITE_DONE,
    output WRITE_ERROR,
    input  REQ_ACK,
    input  RSP_VALID,
    input  RSP_ERROR,
    input  BUSY,
    input  GRANT_ID,
    input  WRITE_START,
    input  WRITE_ADDR,
    input  WRITE_DATA
  );

endinterface

// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 write command port.
// Ports: CLOCK, RESET (async, active-low), bus (slave modport: requests,
// per-requester ack/response pulses, BUSY/GRANT_ID, master command port).
// Optional watchdog on WAIT_RSP: define AXI4_WRITE_ARB_TIMEOUT_EN.
module axi4_write_arbiter #(
  parameter int N_REQ            = 4,
  parameter int P_ADDR_WIDTH     = 32,
  parameter int P_DATA_WIDTH     = 256,
  parameter int P_TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  axi4_write_arbiter_if.slave  bus
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("N_REQ must be 2..8");
  end
  if (P_TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("P_TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              last_q, last_d;
  logic [2:0]              gid_q, gid_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic [N_REQ-1:0]        rsp_q, rsp_d;
  logic [N_REQ-1:0]        rerr_q, rerr_d;
  logic                    busy_q, busy_d;
  logic                    start_q, start_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;

`ifdef AXI4_WRITE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(P_TIMEOUT_CYCLES - 1);
  logic [CW-1:0]           cnt_q, cnt_d;
`endif

  function automatic logic [N_REQ-1:0] onehot(
    input logic [2:0] idx
  );
    onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (3'(j) == idx) onehot[j] = 1'b1;
    end
  endfunction

  // Round-robin pick: first request after last_q, wrapping.
  logic [7:0] req_ext;
  logic       hit;
  logic [2:0] pick;

  always_comb begin
    logic [3:0] idx;
    idx     = '0;
    hit     = 1'b0;
    pick    = '0;
    req_ext = 8'(bus.REQ_VALID);
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, last_q} + 4'(k);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      if (!hit && req_ext[idx[2:0]]) begin
        hit  = 1'b1;
        pick = idx[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    ack_d   = '0;
    rsp_d   = '0;
    rerr_d  = '0;
    busy_d  = busy_q;
    start_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef AXI4_WRITE_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hit && bus.WRITE_READY) begin
          gid_d   = pick;
          ack_d   = onehot(pick);
          busy_d  = 1'b1;
          state_d = ISSUE;
          for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == pick) begin
              addr_d = bus.REQ_ADDR[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
              data_d = bus.REQ_DATA[i*P_DATA_WIDTH +: P_DATA_WIDTH];
            end
          end
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        state_d = WAIT_RSP;
`ifdef AXI4_WRITE_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_RSP: begin
        if (bus.WRITE_DONE || bus.WRITE_ERROR) begin
          rsp_d   = onehot(gid_q);
          rerr_d  = bus.WRITE_ERROR ? onehot(gid_q) : '0;
          state_d = RESP;
        end
`ifdef AXI4_WRITE_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LIM) begin
          rsp_d   = onehot(gid_q);
          rerr_d  = onehot(gid_q);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        last_d  = gid_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      last_q  <= 3'(N_REQ - 1);
      gid_q   <= '0;
      ack_q   <= '0;
      rsp_q   <= '0;
      rerr_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
      rerr_q  <= rerr_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef AXI4_WRITE_ARB_TIMEOUT_EN
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.REQ_ACK     = ack_q;
  assign bus.RSP_VALID   = rsp_q;
  assign bus.RSP_ERROR   = rerr_q;
  assign bus.BUSY        = busy_q;
  assign bus.GRANT_ID    = gid_q;
  assign bus.WRITE_START = start_q;
  assign bus.WRITE_ADDR  = addr_q;
  assign bus.WRITE_DATA  = data_q;

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Directed bench for axi4_write_arbiter: vector table plus
// hand sequences for round-robin, async reset and watchdog.
module tb_axi4_write_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 256;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   starts;

  axi4_write_arbiter_if #(
    .N_REQ(NR), .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)
  ) bus ();

  axi4_write_arbiter #(
    .N_REQ(NR), .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW),
    .P_TIMEOUT_CYCLES(16)
  ) dut (
    .CLOCK(clk),
    .RESET(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    req;
    logic          rdy;
    logic          done;
    logic          err;
    logic [3:0]    ack;
    logic          start;
    logic [3:0]    rsp;
    logic [3:0]    rerr;
    logic          busy;
    logic [2:0]    gid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(
    input logic [3:0] req, input logic rdy,
    input logic done, input logic err,
    input logic [3:0] ack, input logic start,
    input logic [3:0] rsp, input logic [3:0] rerr,
    input logic busy, input logic [2:0] gid,
    input logic [AW-1:0] addr, input logic [DW-1:0] data
  );
    vec_t v;
    v.req = req; v.rdy = rdy; v.done = done; v.err = err;
    v.ack = ack; v.start = start; v.rsp = rsp; v.rerr = rerr;
    v.busy = busy; v.gid = gid; v.addr = addr; v.data = data;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (bus.WRITE_START) starts++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.REQ_VALID   = '0;
    bus.WRITE_READY = 1'b0;
    bus.WRITE_DONE  = 1'b0;
    bus.WRITE_ERROR = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ack"},   DW'(bus.REQ_ACK),     '0);
    chk({tag, " start"}, DW'(bus.WRITE_START), '0);
    chk({tag, " rsp"},   DW'(bus.RSP_VALID),   '0);
    chk({tag, " rerr"},  DW'(bus.RSP_ERROR),   '0);
    chk({tag, " busy"},  DW'(bus.BUSY),        '0);
    chk({tag, " gid"},   DW'(bus.GRANT_ID),    '0);
    chk({tag, " addr"},  DW'(bus.WRITE_ADDR),  '0);
    chk({tag, " data"},  bus.WRITE_DATA,       '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "hang");
  end

  initial begin
    logic [3:0] oh;
    logic [3:0] any_rsp;
    int k;
    total = 0;
    bad   = 0;
    starts = 0;
    rst_n = 1'b0;
    bus.REQ_VALID   = '0;
    bus.WRITE_READY = 1'b0;
    bus.WRITE_DONE  = 1'b0;
    bus.WRITE_ERROR = 1'b0;
    bus.REQ_ADDR = {32'h30, 32'h20, 32'h10, 32'h00};
    bus.REQ_DATA = {256'hF3, 256'hF2, 256'hF4, 256'hF1};

    //        req  r d e  ack st rsp re b gid addr   data
    tbl[0]  = mk(1, 1,0,0, 1, 0, 0, 0, 1, 0, 'h00, 'hF1);
    tbl[1]  = mk(0, 1,0,0, 0, 1, 0, 0, 1, 0, 'h00, 'hF1);
    tbl[2]  = mk(0, 1,0,0, 0, 0, 0, 0, 1, 0, 'h00, 'hF1);
    tbl[3]  = mk(0, 1,1,0, 0, 0, 1, 0, 1, 0, 'h00, 'hF1);
    tbl[4]  = mk(0, 1,0,0, 0, 0, 0, 0, 0, 0, 'h00, 'hF1);
    tbl[5]  = mk(4, 1,0,0, 4, 0, 0, 0, 1, 2, 'h20, 'hF2);
    tbl[6]  = mk(0, 1,0,0, 0, 1, 0, 0, 1, 2, 'h20, 'hF2);
    tbl[7]  = mk(0, 1,0,1, 0, 0, 4, 4, 1, 2, 'h20, 'hF2);
    tbl[8]  = mk(0, 1,0,0, 0, 0, 0, 0, 0, 2, 'h20, 'hF2);
    tbl[9]  = mk(1, 1,0,0, 1, 0, 0, 0, 1, 0, 'h00, 'hF1);
    tbl[10] = mk(0, 1,0,0, 0, 1, 0, 0, 1, 0, 'h00, 'hF1);
    tbl[11] = mk(0, 1,1,1, 0, 0, 1, 1, 1, 0, 'h00, 'hF1);
    tbl[12] = mk(0, 1,0,0, 0, 0, 0, 0, 0, 0, 'h00, 'hF1);
    tbl[13] = mk(2, 0,1,0, 0, 0, 0, 0, 0, 0, 'h00, 'hF1);
    tbl[14] = mk(2, 0,0,0, 0, 0, 0, 0, 0, 0, 'h00, 'hF1);
    tbl[15] = mk(2, 1,0,0, 2, 0, 0, 0, 1, 1, 'h10, 'hF4);
    tbl[16] = mk(0, 1,0,0, 0, 1, 0, 0, 1, 1, 'h10, 'hF4);
    tbl[17] = mk(0, 1,1,0, 0, 0, 2, 0, 1, 1, 'h10, 'hF4);
    tbl[18] = mk(0, 1,0,0, 0, 0, 0, 0, 0, 1, 'h10, 'hF4);

    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 19; i++) begin
      bus.REQ_VALID   = tbl[i].req;
      bus.WRITE_READY = tbl[i].rdy;
      bus.WRITE_DONE  = tbl[i].done;
      bus.WRITE_ERROR = tbl[i].err;
      step();
      chk($sformatf("row%0d ack", i),
          DW'(bus.REQ_ACK), DW'(tbl[i].ack));
      chk($sformatf("row%0d start", i),
          DW'(bus.WRITE_START), DW'(tbl[i].start));
      chk($sformatf("row%0d rsp", i),
          DW'(bus.RSP_VALID), DW'(tbl[i].rsp));
      chk($sformatf("row%0d rerr", i),
          DW'(bus.RSP_ERROR), DW'(tbl[i].rerr));
      chk($sformatf("row%0d busy", i),
          DW'(bus.BUSY), DW'(tbl[i].busy));
      chk($sformatf("row%0d gid", i),
          DW'(bus.GRANT_ID), DW'(tbl[i].gid));
      chk($sformatf("row%0d addr", i),
          DW'(bus.WRITE_ADDR), DW'(tbl[i].addr));
      chk($sformatf("row%0d data", i),
          bus.WRITE_DATA, tbl[i].data);
    end

    // Round-robin with all four requesting.
    do_reset();
    starts = 0;
    bus.REQ_VALID   = 4'b1111;
    bus.WRITE_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      k = 0;
      while (bus.REQ_ACK == '0 && k < 8) begin
        step();
        k++;
      end
      chk($sformatf("rr%0d ack", i), DW'(bus.REQ_ACK), DW'(oh));
      chk($sformatf("rr%0d gid", i), DW'(bus.GRANT_ID), DW'(i % 4));
      step();
      step();
      step();
      bus.WRITE_DONE = 1'b1;
      step();
      bus.WRITE_DONE = 1'b0;
      chk($sformatf("rr%0d rsp", i), DW'(bus.RSP_VALID), DW'(oh));
    end
    bus.REQ_VALID = '0;
    step();
    step();
    step();
    chk("rr starts", DW'(starts), DW'(5));

    // Async reset while waiting for the response.
    do_reset();
    bus.REQ_VALID   = 4'b1001;
    bus.WRITE_READY = 1'b1;
    step();
    chk("mid ack", DW'(bus.REQ_ACK), DW'(1));
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid async");
    @(negedge clk);
    rst_n = 1'b1;
    any_rsp = '0;
    step();
    any_rsp |= bus.RSP_VALID;
    chk("post ack", DW'(bus.REQ_ACK), DW'(1));
    chk("post gid", DW'(bus.GRANT_ID), DW'(0));
    bus.REQ_VALID = '0;
    step();
    any_rsp |= bus.RSP_VALID;
    chk("post no rsp", DW'(any_rsp), '0);

`ifdef AXI4_WRITE_ARB_TIMEOUT_EN
    do_reset();
    bus.REQ_VALID   = 4'b0001;
    bus.WRITE_READY = 1'b1;
    step();
    bus.REQ_VALID = '0;
    step();
    chk("to start", DW'(bus.WRITE_START), DW'(1));
    any_rsp = '0;
    for (int i = 1; i < 16; i++) begin
      step();
      any_rsp |= bus.RSP_VALID;
    end
    chk("to early", DW'(any_rsp), '0);
    step();
    chk("to rsp", DW'(bus.RSP_VALID), DW'(1));
    chk("to rerr", DW'(bus.RSP_ERROR), DW'(1));
    step();
    bus.WRITE_DONE = 1'b1;
    step();
    bus.WRITE_DONE = 1'b0;
    step();
    chk("late rsp", DW'(bus.RSP_VALID), '0);
    chk("late busy", DW'(bus.BUSY), '0);
`else
    do_reset();
    bus.REQ_VALID   = 4'b0001;
    bus.WRITE_READY = 1'b1;
    step();
    bus.REQ_VALID = '0;
    any_rsp = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      any_rsp |= bus.RSP_VALID;
    end
    chk("wait rsp", DW'(any_rsp), '0);
    chk("wait busy", DW'(bus.BUSY), DW'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
